updown_step_driver: RTL and testbench

- Initiator side of the UP/DOWN/CO/EF/FF counter interface.
- On a START request, drives the counter from its present CO to a requested TARGET using single-cycle UP or DOWN pulses.
- After each pulse, waits a settle window and checks CO before issuing the next pulse.
- Reports completion (DONE), progress (STEPS) and fault (ERR). Sits between control logic and the counter.

---
 rtl/updown_step_driver_pkg.sv | 20 ++
 rtl/updown_step_driver_settle_timer.sv | 28 ++
 rtl/updown_step_driver.sv | 144 ++++++++++++++
 tb/tb_updown_step_driver.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/updown_step_driver_pkg.sv
// Shared definitions for the UP/DOWN counter interface drivers.
//   DEF_W       default count width
//   SETTLE_W    width of the settle timer load value (settle 1..15)
//   state_t     driver FSM state encoding
//   RES_DONE/RES_ERR  result codes for status registers
package updown_step_driver_pkg;
    localparam int DEF_W    = 3;
    localparam int SETTLE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EVAL   = 3'd1,
        ST_PULSE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam logic [1:0] RES_DONE = 2'd1;
    localparam logic [1:0] RES_ERR  = 2'd2;
endpackage

// File: rtl/updown_step_driver_settle_timer.sv
// Loadable down-counter with zero flag.
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset (count cleared)
//   i_load      load i_load_val this edge (wins over decrement)
//   i_load_val  value to load
//   o_zero      count is zero; the counter holds at zero
module updown_step_driver_settle_timer #(
    parameter int CW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_zero
);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - CW'(1);
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/updown_step_driver.sv
// Initiator for an UP/DOWN/CO/EF/FF counter: walks CO to a requested target
// one pulse at a time, checking the counter's response after each pulse.
//   i_clk            clock, rising edge
//   i_mr_n           master reset, asynchronous, active-low
//   i_start          request strobe (only sampled when idle)
//   i_target         requested count, latched on accepted start
//   i_co, i_ef, i_ff counter output and empty/full flags
//   o_up, o_down     single-cycle step pulses to the counter
//   o_busy           request in progress (through the DONE/ERR cycle)
//   o_done, o_err    one-cycle completion / abort pulses
//   o_steps          pulses issued for the current or last request
module updown_step_driver
    import updown_step_driver_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int SETTLE    = 2,
    parameter int MAX_STEPS = 8
) (
    input  logic         i_clk,
    input  logic         i_mr_n,
    input  logic         i_start,
    input  logic [W-1:0] i_target,
    input  logic [W-1:0] i_co,
    input  logic         i_ef,
    input  logic         i_ff,
    output logic         o_up,
    output logic         o_down,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic [W:0]   o_steps
);
    localparam logic [W:0]          MAX_S    = (W+1)'(MAX_STEPS);
    localparam logic [W:0]          ONE_S    = (W+1)'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);

    state_t       r_state;
    logic [W-1:0] r_target;
    logic [W-1:0] r_last_co;
    logic         r_up, r_down, r_busy, r_done, r_err;
    logic [W:0]   r_steps;

    logic       w_eq, w_lt, w_gt, w_blocked, w_step;
    logic       w_tmr_zero, w_dir_up, w_moved_ok, w_stuck;
    logic [W:0] w_co_x, w_last_x;

    assign w_eq = (i_co == r_target);
    assign w_lt = (i_co <  r_target);
    assign w_gt = (i_co >  r_target);

    // Refuse to pulse into a full/empty counter, or past the pulse budget.
    assign w_blocked = (w_lt && i_ff) || (w_gt && i_ef) || (r_steps == MAX_S);
    assign w_step    = (r_state == ST_EVAL) && !w_eq && !w_blocked;

    // Widened by one bit so the +1 checks cannot wrap at the ends of the range.
    assign w_co_x     = {1'b0, i_co};
    assign w_last_x   = {1'b0, r_last_co};
    assign w_dir_up   = (r_target > r_last_co);
    assign w_moved_ok = w_dir_up ? (w_co_x == w_last_x + ONE_S)
                                 : (w_co_x + ONE_S == w_last_x);
    assign w_stuck    = (i_co == r_last_co);

    // Loaded on the edge that issues the pulse, so the pulse cycle itself
    // counts down once and SETTLE cycles are spent in ST_SETTLE.
    updown_step_driver_settle_timer #(.CW(SETTLE_W)) u_settle (
        .i_clk      (i_clk),
        .i_rst_n    (i_mr_n),
        .i_load     (w_step),
        .i_load_val (SETTLE_V),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge i_clk or negedge i_mr_n) begin
        if (!i_mr_n) begin
            r_state   <= ST_IDLE;
            r_target  <= '0;
            r_last_co <= '0;
            r_up      <= 1'b0;
            r_down    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_steps   <= '0;
        end else begin
            // Pulse-type outputs are high for at most one cycle.
            r_up   <= 1'b0;
            r_down <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_target <= i_target;
                        r_steps  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (w_eq) begin
                        r_done  <= 1'b1;
                        r_state <= ST_FINISH;
                    end else if (w_blocked) begin
                        r_err   <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
                        r_last_co <= i_co;
                        r_up      <= w_lt;
                        r_down    <= !w_lt;
                        if (r_steps != '1)
                            r_steps <= r_steps + ONE_S;
                        r_state   <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_tmr_zero) begin
                        // A stuck counter is retried; the budget bounds it.
                        if (w_moved_ok || w_stuck) begin
                            r_state <= ST_EVAL;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_up    = r_up;
    assign o_down  = r_down;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_steps = r_steps;
endmodule

// File: tb/tb_updown_step_driver.sv
// Bench for updown_step_driver: a small counter model closes the loop, and
// a timeline model predicts every output from the request's expected pulse
// count, direction and result.
module tb_updown_step_driver;
    localparam int SETTLE = 2;
    localparam int L      = SETTLE + 2;   // cycles per step

    logic       clk = 1'b0;
    logic       mr_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] target = '0;
    logic [2:0] co = '0;
    logic       ef, ff;
    logic       up, down, busy, done, err;
    logic [3:0] steps;

    // counter model controls
    logic       ld = 1'b0;
    logic [2:0] ld_val = '0;
    logic       stuck_m = 1'b0;
    logic       force_ff = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_up = 0, n_dn = 0, ef_cnt = 0;

    // timeline model state
    bit chk_en = 1'b0;
    bit act = 1'b0;
    int acc_edge = 0;
    int P = 0;
    bit res_done = 1'b0;
    bit dir_up = 1'b0;
    int hold = 0;

    updown_step_driver #(.W(3), .SETTLE(SETTLE), .MAX_STEPS(8)) dut (
        .i_clk    (clk),
        .i_mr_n   (mr_n),
        .i_start  (start),
        .i_target (target),
        .i_co     (co),
        .i_ef     (ef),
        .i_ff     (ff),
        .o_up     (up),
        .o_down   (down),
        .o_busy   (busy),
        .o_done   (done),
        .o_err    (err),
        .o_steps  (steps)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counter: responds to a pulse on the edge that samples it.
    always @(posedge clk) begin
        if (ld)
            co <= ld_val;
        else if (!stuck_m) begin
            if (up)        co <= co + 3'd1;
            else if (down) co <= co - 3'd1;
        end
    end
    assign ef = (co == 3'd0);
    assign ff = force_ff | (co == 3'd7);

    always @(posedge clk) begin
        if (up)          n_up   <= n_up + 1;
        if (down)        n_dn   <= n_dn + 1;
        if (busy && ef)  ef_cnt <= ef_cnt + 1;
    end

    task automatic chk(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, a, e, $time);
        end
    endtask

    // Timeline model: m = edges since the accepting edge. Pulse j appears
    // after edge 1+j*L, the result after edge 1+P*L, busy through that cycle.
    int cm, cend, e_busy, e_up, e_dn, e_done, e_err, e_steps, pls;
    always @(negedge clk) begin
        if (chk_en) begin
            if (act) begin
                cm   = cyc - acc_edge;
                cend = 1 + P * L;
                e_busy = (cm >= 0 && cm <= cend) ? 1 : 0;
                e_done = (cm == cend && res_done) ? 1 : 0;
                e_err  = (cm == cend && !res_done) ? 1 : 0;
                pls    = (cm >= 1 && cm < cend && ((cm - 1) % L) == 0) ? 1 : 0;
                e_up   = (pls != 0 && dir_up) ? 1 : 0;
                e_dn   = (pls != 0 && !dir_up) ? 1 : 0;
                if (cm < 1) e_steps = 0;
                else begin
                    e_steps = (cm - 1) / L + 1;
                    if (e_steps > P) e_steps = P;
                end
            end else begin
                e_busy = 0; e_done = 0; e_err = 0; e_up = 0; e_dn = 0;
                e_steps = hold;
            end
            chk("busy", int'(busy), e_busy);
            chk("up", int'(up), e_up);
            chk("down", int'(down), e_dn);
            chk("done", int'(done), e_done);
            chk("err", int'(err), e_err);
            chk("steps", int'(steps), e_steps);
        end
    end

    task automatic run_req(input bit do_load, input logic [2:0] co0,
                           input logic [2:0] tgt, input int p, input bit rd,
                           input bit updir, input bit stk, input bit fff);
        int up0, dn0, endm;
        @(negedge clk); #1;
        if (do_load) begin ld = 1'b1; ld_val = co0; end
        stuck_m = stk; force_ff = fff;
        @(negedge clk); #1;
        ld = 1'b0;
        start = 1'b1; target = tgt;
        acc_edge = cyc + 1; P = p; res_done = rd; dir_up = updir; act = 1'b1;
        up0 = n_up; dn0 = n_dn;
        endm = 1 + p * L;
        @(negedge clk); #1;
        start = 1'b0;
        target = ~tgt;               // must not affect the running request
        if (endm > 3) begin          // a start while busy must be ignored
            @(negedge clk); #1; start = 1'b1;
            @(negedge clk); #1; start = 1'b0;
        end
        repeat (endm + 2) @(negedge clk);
        #1;
        chk("n_up", n_up - up0, updir ? p : 0);
        chk("n_down", n_dn - dn0, updir ? 0 : p);
        chk("final_steps", int'(steps), p);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_up", int'(up | down), 0);
        chk("rst_steps", int'(steps), 0);
        #1; mr_n = 1'b1; chk_en = 1'b1;

        // 0 -> 5: five UPs four cycles apart, DONE
        run_req(1'b1, 3'd0, 3'd5, 5, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t1_co", int'(co), 5);
        chk("t1_steps", int'(steps), 5);

        // 7 -> 2: five DOWNs, EF never seen while busy
        ef_cnt = 0;
        run_req(1'b1, 3'd7, 3'd2, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_co", int'(co), 2);
        chk("t2_ef", ef_cnt, 0);

        // 3 -> 3: no pulse, DONE in the cycle after EVAL
        run_req(1'b1, 3'd3, 3'd3, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_steps", int'(steps), 0);

        // stuck at 4, target 6: eight UPs then ERR
        run_req(1'b1, 3'd4, 3'd6, 8, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_steps", int'(steps), 8);
        chk("t4_busy", int'(busy), 0);
        chk("t4_co", int'(co), 4);

        // FF forced with CO=3 below target: ERR straight from EVAL
        run_req(1'b1, 3'd3, 3'd5, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t5_co", int'(co), 3);

        // reset mid-move while the second UP is on the wire
        @(negedge clk); #1;
        force_ff = 1'b0; stuck_m = 1'b0; ld = 1'b1; ld_val = 3'd0;
        @(negedge clk); #1;
        ld = 1'b0; start = 1'b1; target = 3'd5;
        acc_edge = cyc + 1; P = 5; res_done = 1'b1; dir_up = 1'b1; act = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);   // m = 5: second UP high here
        #1; mr_n = 1'b0; chk_en = 1'b0;
        #1;
        chk("mr_up", int'(up), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_steps", int'(steps), 0);
        @(negedge clk); #1;
        act = 1'b0; hold = 0; mr_n = 1'b1; chk_en = 1'b1;
        chk("mr_co", int'(co), 1);   // only the first UP reached the counter

        // normal request after reset release: 1 -> 3
        run_req(1'b0, 3'd0, 3'd3, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_co", int'(co), 3);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
